// File: rtl/fb_scanout.sv
// Frame-buffer scanout: reads a 2^ROW_LOG2 x 2^COL_LOG2 frame in raster order from a
// single-port SRAM and streams it on valid/ready through a 2-entry skid FIFO.
module fb_scanout #(
  parameter int COL_LOG2 = 6,
  parameter int ROW_LOG2 = 6,
  parameter int PIX_W    = 12
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         done,
  output logic                         FB_CEN,
  output logic [COL_LOG2+ROW_LOG2-1:0] FB_A,
  input  logic [PIX_W-1:0]             FB_Q,
  output logic                         pix_valid,
  input  logic                         pix_ready,
  output logic [PIX_W-1:0]             pix_data,
  output logic                         pix_sof,
  output logic                         pix_eol,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         overrun
);
  localparam int AW = COL_LOG2 + ROW_LOG2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic             sof;
    logic             eol;
  } ent_t;

  state_t        state, state_nx;
  logic          done_d, start;
  logic [AW-1:0] cnt, a_last;
  logic          if_vld, if_sof, if_eol;
  ent_t          mem [2];
  logic          rp, wp;
  logic [1:0]    occ, eff;
  logic          push, pop, issue, last_pop;
  ent_t          head;

  assign start = done & ~done_d;
  assign push  = if_vld;
  assign pop   = pix_valid & pix_ready;
  // Occupancy seen by the issue rule credits this cycle's pop, so a full-rate
  // consumer never sees a bubble.
  assign eff      = occ + {1'b0, if_vld} - {1'b0, pop};
  assign issue    = (state == RUN) && (eff < 2'd2);
  assign last_pop = (state == DRAIN) && pop && (occ == 2'd1) && !if_vld;
  assign head     = mem[rp];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (issue && (cnt == {AW{1'b1}})) state_nx = DRAIN;
      DRAIN:   if (last_pop) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    FB_CEN    = ~issue;
    FB_A      = issue ? cnt : a_last;
    busy      = (state != IDLE);
    pix_valid = (occ != 2'd0);
    pix_data  = head.data;
    pix_sof   = head.sof;
    pix_eol   = head.eol;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_d     <= 1'b0;
      cnt        <= '0;
      a_last     <= '0;
      if_vld     <= 1'b0;
      if_sof     <= 1'b0;
      if_eol     <= 1'b0;
      mem[0]     <= '0;
      mem[1]     <= '0;
      rp         <= 1'b0;
      wp         <= 1'b0;
      occ        <= 2'd0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      done_d <= done;
      if (state == IDLE && start) cnt <= '0;
      else if (issue)             cnt <= cnt + 1'b1;
      if (issue) a_last <= cnt;
      if_vld <= issue;
      if_sof <= (cnt == '0);
      if_eol <= &cnt[COL_LOG2-1:0];
      if (push) begin
        mem[wp] <= '{data: FB_Q, sof: if_sof, eol: if_eol};
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      occ        <= occ + {1'b0, push} - {1'b0, pop};
      frame_done <= last_pop;
      overrun    <= overrun | (start & busy);
    end
  end
endmodule
